// File: rtl/dec_sequencer.sv
// Transaction sequencer for the EncDec datapath: runs one encode strobe or a
// syndrome -> correction -> capture chain per start, and keeps error statistics.
module dec_sequencer #(
    parameter int AMBA_WORD = 32,
    parameter int TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] ctrl,
    input  logic [1:0] data_width,
    input  logic       syn_valid,
    input  logic [1:0] nof_in,
    input  logic       clear_stats,
    output logic       busy,
    output logic       enc_go,
    output logic       syn_start,
    output logic       fix_en,
    output logic       fix_small,
    output logic       fix_medium,
    output logic       dec_valid,
    output logic       done,
    output logic [1:0] num_of_errors,
    output logic       cfg_err,
    output logic       timeout_err,
    output logic [7:0] corr_cnt,
    output logic [7:0] uncorr_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ENC  = 3'd1;
    localparam logic [2:0] S_SYND = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_FIX  = 3'd4;
    localparam logic [2:0] S_CAPT = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    if (TIMEOUT < 2 || TIMEOUT > 255 || AMBA_WORD < 1) begin : g_bad_param
        $error("dec_sequencer: TIMEOUT must be 2..255 and AMBA_WORD positive");
    end

    logic [2:0] state;
    logic [7:0] wait_cnt;
    logic [1:0] ctrl_q;
    logic [1:0] width_q;
    logic       stat_upd;

    // Strobes are pure state decodes so each lasts exactly one cycle.
    assign busy       = (state != S_IDLE);
    assign enc_go     = (state == S_ENC);
    assign syn_start  = (state == S_SYND);
    assign fix_en     = (state == S_FIX);
    assign dec_valid  = (state == S_CAPT);
    assign done       = (state == S_DONE);
    assign fix_small  = busy && (width_q == 2'b00);
    assign fix_medium = busy && (width_q == 2'b01);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            ctrl_q        <= '0;
            width_q       <= '0;
            num_of_errors <= '0;
            cfg_err       <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    ctrl_q        <= ctrl;
                    width_q       <= data_width;
                    num_of_errors <= 2'b00;
                    timeout_err   <= 1'b0;
                    cfg_err       <= 1'b0;
                    if (ctrl == 2'b11 || data_width == 2'b11) begin
                        cfg_err <= 1'b1;
                        state   <= S_DONE;
                    end else if (ctrl == 2'b00) begin
                        state <= S_ENC;
                    end else begin
                        state <= S_SYND;
                    end
                end
                S_ENC:  state <= S_DONE;
                S_SYND: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                // syn_valid is tested first so it beats the timeout on the last cycle
                S_WAIT: begin
                    if (syn_valid) begin
                        num_of_errors <= nof_in;
                        state         <= S_FIX;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err   <= 1'b1;
                        num_of_errors <= 2'b11;
                        state         <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_FIX:  state <= S_CAPT;
                S_CAPT: state <= S_DONE;
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Only completed decode-type transactions feed the statistics.
    assign stat_upd = done && !cfg_err && (ctrl_q != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (clear_stats) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (stat_upd) begin
            if (num_of_errors == 2'b01 && corr_cnt != 8'hFF)
                corr_cnt <= corr_cnt + 8'd1;
            if (num_of_errors[1] && uncorr_cnt != 8'hFF)
                uncorr_cnt <= uncorr_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_dec_sequencer.sv
// Bench for dec_sequencer: directed timeline cases plus random transactions
// checked against a transaction-level timeline and statistics model.
module tb_dec_sequencer;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, syn_valid, clear_stats;
    logic [1:0] ctrl, data_width, nof_in;
    logic       busy, enc_go, syn_start, fix_en, fix_small, fix_medium, dec_valid, done;
    logic [1:0] num_of_errors;
    logic       cfg_err, timeout_err;
    logic [7:0] corr_cnt, uncorr_cnt;

    int n_chk = 0;
    int n_err = 0;

    int m_corr, m_uncorr;
    logic [1:0] m_nerr;
    logic m_cfg, m_to;

    dec_sequencer #(.AMBA_WORD(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .data_width(data_width),
        .syn_valid(syn_valid), .nof_in(nof_in), .clear_stats(clear_stats),
        .busy(busy), .enc_go(enc_go), .syn_start(syn_start), .fix_en(fix_en),
        .fix_small(fix_small), .fix_medium(fix_medium), .dec_valid(dec_valid),
        .done(done), .num_of_errors(num_of_errors), .cfg_err(cfg_err),
        .timeout_err(timeout_err), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Strobe vector order: busy enc_go syn_start fix_en fix_small fix_medium dec_valid done
    function automatic logic [7:0] strobes();
        return {busy, enc_go, syn_start, fix_en, fix_small, fix_medium, dec_valid, done};
    endfunction

    task automatic chk_results(input string tag);
        chk({tag, "_res"}, {28'd0, num_of_errors, cfg_err, timeout_err},
            {28'd0, m_nerr, m_cfg, m_to});
        chk({tag, "_cnt"}, {16'd0, corr_cnt, uncorr_cnt},
            {16'd0, m_corr[7:0], m_uncorr[7:0]});
    endtask

    // d: WAIT cycle (0-based) on which syn_valid rises; negative or >= TIMEOUT means never.
    // Entered and left at #1 after a rising edge with the DUT in IDLE.
    task automatic run_txn(input string tag, input logic [1:0] c, input logic [1:0] w,
                           input int d, input logic [1:0] nof, input bit clr, input bit noise);
        bit illegal, enc, dec, to;
        int last, fixc;
        logic [7:0] exp_s;
        illegal = (c == 2'b11) || (w == 2'b11);
        enc     = !illegal && (c == 2'b00);
        dec     = !illegal && (c != 2'b00);
        to      = dec && (d < 0 || d >= TIMEOUT);
        fixc    = 3 + d;
        if (illegal)  last = 1;
        else if (enc) last = 2;
        else if (to)  last = 2 + TIMEOUT;
        else          last = 5 + d;

        start = 1'b1; ctrl = c; data_width = w;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cy = 1; cy <= last; cy++) begin
            start       = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
            ctrl        = 2'($urandom);
            data_width  = 2'($urandom);
            nof_in      = 2'($urandom);
            clear_stats = clr && (cy == last);
            if (dec && !to && cy == 2 + d) begin
                syn_valid = 1'b1;
                nof_in    = nof;
            end else if (dec && cy >= 2 && (to || cy < 2 + d)) begin
                syn_valid = 1'b0;
            end else begin
                syn_valid = noise ? 1'($urandom) : 1'b0;
            end
            exp_s = {1'b1, enc && cy == 1, dec && cy == 1, dec && !to && cy == fixc,
                     w == 2'b00, w == 2'b01, dec && !to && cy == fixc + 1, cy == last};
            @(negedge clk);
            chk($sformatf("%s_c%0d", tag, cy), {24'd0, strobes()}, {24'd0, exp_s});
            @(posedge clk); #1;
        end
        start = 1'b0; syn_valid = 1'b0; clear_stats = 1'b0;

        m_cfg  = illegal;
        m_to   = to;
        m_nerr = (illegal || enc) ? 2'b00 : (to ? 2'b11 : nof);
        if (clr) begin
            m_corr = 0; m_uncorr = 0;
        end else if (!illegal) begin
            if (m_nerr == 2'b01) m_corr   = (m_corr   < 255) ? m_corr + 1   : 255;
            if (m_nerr[1])       m_uncorr = (m_uncorr < 255) ? m_uncorr + 1 : 255;
        end
        @(negedge clk);
        chk({tag, "_idle"}, {24'd0, strobes()}, 32'd0);
        chk_results(tag);
        @(posedge clk); #1;
    endtask

    initial begin
        int d;
        logic [1:0] c, w, nof;
        rst = 1'b1; start = 1'b0; ctrl = '0; data_width = '0;
        syn_valid = 1'b0; nof_in = '0; clear_stats = 1'b0;
        m_corr = 0; m_uncorr = 0; m_nerr = '0; m_cfg = 1'b0; m_to = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_strb", {24'd0, strobes()}, 32'd0);
        chk_results("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_txn("dec_small", 2'b01, 2'b00, 0, 2'b01, 1'b0, 1'b0);
        run_txn("enc_large", 2'b00, 2'b10, 0, 2'b00, 1'b0, 1'b0);
        run_txn("tmo",       2'b01, 2'b01, -1, 2'b00, 1'b0, 1'b0);
        run_txn("last_wait", 2'b01, 2'b01, TIMEOUT - 1, 2'b10, 1'b0, 1'b0);
        run_txn("cfg_width", 2'b01, 2'b11, 0, 2'b00, 1'b0, 1'b0);
        run_txn("cfg_ctrl",  2'b11, 2'b00, 0, 2'b00, 1'b0, 1'b0);
        run_txn("full_busy", 2'b10, 2'b10, 4, 2'b01, 1'b0, 1'b1);

        // Reset in the middle of WAIT aborts at once and clears everything.
        start = 1'b1; ctrl = 2'b01; data_width = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrst_strb", {24'd0, strobes()}, 32'd0);
        m_corr = 0; m_uncorr = 0; m_nerr = '0; m_cfg = 1'b0; m_to = 1'b0;
        chk_results("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn("post_rst", 2'b01, 2'b01, 1, 2'b01, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            c   = 2'($urandom);
            w   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            d   = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 1));
            nof = 2'($urandom);
            run_txn($sformatf("rnd%0d", i), c, w, d, nof, $urandom_range(0, 9) == 0, 1'b1);
        end

        for (int i = 0; i < 256; i++)
            run_txn("sat", 2'b01, 2'($urandom_range(0, 2)), 0, 2'b10, 1'b0, 1'b0);
        chk("sat_uncorr", {24'd0, uncorr_cnt}, 32'd255);
        run_txn("sat_clr", 2'b01, 2'b10, 0, 2'b10, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dec_sequencer.md
Name: dec_sequencer

Overview:
- Control FSM that sequences one encode or decode transaction through the EncDec datapath.
- On a start pulse it latches the operation and codeword width, then either issues an encode strobe or runs the decode chain: syndrome calculation, single-error correction, registered output capture.
- Drives the width selects and load enable of the error-correction stage, reports the error count per transaction and keeps saturating statistics.
- Sits between the APB register block (start/CTRL/width) and the syndrome and error-fix datapath.

Parameters:
- AMBA_WORD, 32, data word width (width of the correction stage output bus; passed through for consistency, not used internally).
- TIMEOUT, 15, maximum cycles spent in WAIT for syn_valid; legal range 2..255.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request from register block.
- ctrl  input  2  operation: 00 encode, 01 decode, 10 full channel (treated as decode), 11 illegal.
- data_width  input  2  00 8-bit (small), 01 16-bit (medium), 10 32-bit (large), 11 illegal.
- syn_valid  input  1  syndrome stage result valid.
- nof_in  input  2  number-of-errors from syndrome stage (00 none, 01 one, 1x uncorrectable).
- clear_stats  input  1  synchronous clear of statistics counters.
- busy  output  1  high in every state except IDLE.
- enc_go  output  1  one-cycle encode strobe.
- syn_start  output  1  one-cycle syndrome launch.
- fix_en  output  1  one-cycle load enable of the correction output register.
- fix_small  output  1  latched width==00, held while busy.
- fix_medium  output  1  latched width==01, held while busy.
- dec_valid  output  1  corrected word valid on datapath output.
- done  output  1  one-cycle completion pulse.
- num_of_errors  output  2  result of last transaction.
- cfg_err  output  1  last transaction rejected (illegal ctrl/width).
- timeout_err  output  1  last transaction timed out.
- corr_cnt  output  8  count of corrected (single-error) words, saturating.
- uncorr_cnt  output  8  count of uncorrectable words plus timeouts, saturating.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, wait counter 0, latched ctrl/width 0. Reset mid-transaction aborts immediately; no done is issued.
- States:
  - IDLE: on start, latch ctrl/width and clear cfg_err, timeout_err and num_of_errors.
    - ctrl==11 or width==11: go to DONE with cfg_err=1.
    - ctrl==00: go to ENC.
    - Otherwise: go to SYND.
  - ENC: enc_go=1 for one cycle, then DONE; num_of_errors=00.
  - SYND: syn_start=1 for one cycle, wait counter cleared, then WAIT.
  - WAIT: on syn_valid, capture nof_in into num_of_errors and go to FIX. Otherwise increment the counter; when it reaches TIMEOUT-1 with no syn_valid, go to DONE with timeout_err=1 and num_of_errors=11. syn_valid on the last allowed cycle wins over timeout. WAIT lasts at most TIMEOUT cycles.
  - FIX: fix_en=1 for one cycle (correction stage registers its output at the end of this cycle), then CAPT.
  - CAPT: dec_valid=1 for one cycle, then DONE.
  - DONE: done=1 for one cycle, counters updated, then IDLE.
- Result retention: num_of_errors, cfg_err and timeout_err hold until the next accepted start.
- Select outputs: fix_small/fix_medium are decoded from the latched width, never the live input. They return to 0 in IDLE.
- Latency, decode with syn_valid at first WAIT cycle: start sampled at cycle 0, syn_start at 1, WAIT at 2, fix_en at 3, dec_valid at 4, done at 5.
- Latency, encode: enc_go at cycle 1, done at 2.
- Latency, rejected config: done at cycle 1.
- start while busy is ignored and not queued. start in the same cycle DONE returns to IDLE is ignored; it is accepted only when sampled in IDLE.
- Counters, updated in DONE:
  - corr_cnt +1 if num_of_errors==01.
  - uncorr_cnt +1 if num_of_errors[1]==1 (includes timeouts).
  - Both saturate at 255.
  - cfg_err transactions count nothing.
  - clear_stats coincident with an increment: clear wins, result 0.

Test Plan:
- rst high mid-WAIT -> all outputs 0 immediately, busy=0; after release, start decode completes normally.
- ctrl=01, width=00, syn_valid one cycle after syn_start, nof_in=01 -> fix_small=1 through CAPT, fix_en at cycle 3, done at 5, num_of_errors=01, corr_cnt 0->1.
- ctrl=00, width=10 -> enc_go at cycle 1, done at 2, no syn_start/fix_en, counters unchanged.
- ctrl=01, width=01, syn_valid never asserted, TIMEOUT=15 -> exactly 15 WAIT cycles, then done with timeout_err=1, num_of_errors=11, uncorr_cnt +1. Repeat with syn_valid on the 15th WAIT cycle -> no timeout.
- width=11 -> done at cycle 1, cfg_err=1, no datapath strobes; start pulses during a busy decode are ignored.
- 256 nof_in=10 transactions -> uncorr_cnt saturates at 255. clear_stats asserted in a DONE cycle -> 0.
